// File: rtl/sram_sdi_arbiter.sv
// Serial SRAM controller in SDI (dual-lane) mode. After reset it runs RSTIO and
// EDIO, then serves single-byte reads and writes from two round-robin ports.
// All pin-facing outputs are registered and decoded from next-state values,
// so CS/SCK/SIO never glitch.
module sram_sdi_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter bit INIT_EN    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ready,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [15:0] a_addr,
    input  logic [7:0]  a_wdata,
    output logic        a_ack,
    output logic [7:0]  a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [15:0] b_addr,
    input  logic [7:0]  b_wdata,
    output logic        b_ack,
    output logic [7:0]  b_rdata,
    output logic        sck,
    output logic        cs,
    output logic [1:0]  sio_out,
    output logic [1:0]  sio_oe,
    input  logic [1:0]  sio_in
);

    typedef enum logic [3:0] {
        S_BOOT, S_RSTIO, S_EDIO, S_GAP, S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;       // clk cycles spent in the current state
    logic [31:0] sh_q, sh_d;         // outgoing bits, MSB leaves first
    logic [7:0]  rx_q, rx_d;
    logic        we_q, we_d;
    logic        gnt_b_q, gnt_b_d;   // current frame belongs to port B
    logic        last_b_q, last_b_d; // B was granted last; reset value makes A preferred
    logic        edio_next_q, edio_next_d; // the running gap is the one between RSTIO and EDIO
    logic        ready_q, ready_d;
    logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [7:0]  a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic        cs_q, cs_d, sck_q, sck_d;
    logic [1:0]  sio_out_q, sio_out_d, sio_oe_q, sio_oe_d;
    logic        pick_b, frame_d;

    // State, counters, shift registers and all registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BOOT;
            cnt_q       <= '0;
            sh_q        <= '0;
            rx_q        <= '0;
            we_q        <= 1'b0;
            gnt_b_q     <= 1'b0;
            last_b_q    <= 1'b1;
            edio_next_q <= 1'b0;
            ready_q     <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            cs_q        <= 1'b1;
            sck_q       <= 1'b0;
            sio_out_q   <= '0;
            sio_oe_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            rx_q        <= rx_d;
            we_q        <= we_d;
            gnt_b_q     <= gnt_b_d;
            last_b_q    <= last_b_d;
            edio_next_q <= edio_next_d;
            ready_q     <= ready_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            cs_q        <= cs_d;
            sck_q       <= sck_d;
            sio_out_q   <= sio_out_d;
            sio_oe_q    <= sio_oe_d;
        end
    end

    // Next-state: sequencing, arbitration, shifting and read capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 16'd1;
        sh_d        = sh_q;
        rx_d        = rx_q;
        we_d        = we_q;
        gnt_b_d     = gnt_b_q;
        last_b_d    = last_b_q;
        edio_next_d = edio_next_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        pick_b      = b_req && (!a_req || !last_b_q);
        case (state_q)
            S_BOOT: begin
                cnt_d   = '0;
                state_d = INIT_EN ? S_RSTIO : S_IDLE;
            end
            S_RSTIO: begin
                if (cnt_q == 16'd7) begin
                    state_d     = S_GAP;
                    cnt_d       = '0;
                    edio_next_d = 1'b1;
                end
            end
            S_EDIO: begin
                // single-lane SPI: one bit per SCK, advanced at end of the high cycle
                if (cnt_q[0]) sh_d = sh_q << 1;
                if (cnt_q == 16'd15) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (edio_next_q) begin
                        state_d     = S_EDIO;
                        edio_next_d = 1'b0;
                        sh_d        = {8'h3B, 24'h0};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (ready_q && (a_req || b_req)) begin
                    gnt_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = pick_b ? b_we : a_we;
                    sh_d     = pick_b ? {(b_we ? 8'h02 : 8'h03), b_addr, b_wdata}
                                      : {(a_we ? 8'h02 : 8'h03), a_addr, a_wdata};
                    state_d  = S_CMD;
                end
            end
            S_CMD: begin
                if (cnt_q[0]) sh_d = sh_q << 2;
                if (cnt_q == 16'd7) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                if (cnt_q[0]) sh_d = sh_q << 2;
                if (cnt_q == 16'd15) begin
                    state_d = we_q ? S_DATA : S_DUMMY;
                    cnt_d   = '0;
                end
            end
            S_DUMMY: begin
                if (cnt_q == 16'd7) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (we_q) begin
                    if (cnt_q[0]) sh_d = sh_q << 2;
                end else if (cnt_q[0]) begin
                    // sample on the edge that ends the SCK high cycle
                    rx_d = {rx_q[5:0], sio_in};
                end
                if (cnt_q == 16'd7) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    a_ack_d = !gnt_b_q;
                    b_ack_d = gnt_b_q;
                    if (!we_q) begin
                        if (gnt_b_q) b_rdata_d = {rx_q[5:0], sio_in};
                        else         a_rdata_d = {rx_q[5:0], sio_in};
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin decode from next-state values so the pins flop in step with the FSM
    always_comb begin
        frame_d   = state_d inside {S_RSTIO, S_EDIO, S_CMD, S_ADDR, S_DUMMY, S_DATA};
        cs_d      = !frame_d;
        sck_d     = frame_d && cnt_d[0];
        ready_d   = ready_q || (state_d == S_IDLE);
        sio_oe_d  = 2'b00;
        sio_out_d = 2'b00;
        case (state_d)
            S_RSTIO: begin
                sio_oe_d  = 2'b11;
                sio_out_d = 2'b11;
            end
            S_EDIO: begin
                sio_oe_d  = 2'b01;
                sio_out_d = {1'b0, sh_d[31]};
            end
            S_CMD, S_ADDR: begin
                sio_oe_d  = 2'b11;
                sio_out_d = sh_d[31:30];
            end
            S_DATA: begin
                if (we_d) begin
                    sio_oe_d  = 2'b11;
                    sio_out_d = sh_d[31:30];
                end
            end
            default: begin
                sio_oe_d  = 2'b00;
                sio_out_d = 2'b00;
            end
        endcase
    end

    assign ready   = ready_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign cs      = cs_q;
    assign sck     = sck_q;
    assign sio_out = sio_out_q;
    assign sio_oe  = sio_oe_q;

endmodule

// File: tb/tb_sram_sdi_arbiter.sv
// Directed bench for sram_sdi_arbiter: init sequence, request-before-ready,
// write/read frame lane contents, round-robin alternation and reset mid-frame.
module tb_sram_sdi_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr = '0;
    logic [7:0]  a_wdata = '0;
    logic        a_ack;
    logic [7:0]  a_rdata;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr = '0;
    logic [7:0]  b_wdata = '0;
    logic        b_ack;
    logic [7:0]  b_rdata;
    logic        sck, cs;
    logic [1:0]  sio_out, sio_oe;
    logic [1:0]  sio_in = 2'b00;

    int n_chk = 0;
    int n_fail = 0;

    sram_sdi_arbiter #(.GAP_CYCLES(2), .INIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .sck(sck), .cs(cs), .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Called in cycle 0 (reset just released, before its negedge). Walks to cycle 29.
    task automatic check_init(input bit req_a_at5);
        logic [7:0] edio;
        logic [8:0] exp;
        int j;
        edio = 8'h3B;
        for (int c = 0; c <= 29; c++) begin
            @(negedge clk);
            // {cs, sck, oe, out, ready, a_ack, b_ack}
            if (c >= 1 && c <= 8)
                exp = {1'b0, 1'(c - 1), 2'b11, 2'b11, 3'b000};
            else if (c >= 11 && c <= 26) begin
                j = c - 11;
                exp = {1'b0, 1'(j), 2'b01, 1'b0, edio[7 - j / 2], 3'b000};
            end else if (c == 29)
                exp = {1'b1, 1'b0, 4'b0000, 3'b100};
            else
                exp = {1'b1, 8'b0};
            chk($sformatf("init c%0d", c), 32'({cs, sck, sio_oe, sio_out, ready, a_ack, b_ack}), 32'(exp));
            if (req_a_at5 && c == 5) begin
                a_req = 1'b1; a_we = 1'b1; a_addr = 16'h1234; a_wdata = 8'hA5;
            end
        end
    endtask

    // Called at the negedge of the grant cycle T; returns at the negedge of the ack cycle.
    task automatic check_frame(input string tag, input bit is_b, input bit we,
                               input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd);
        logic [31:0] tx;
        logic [7:0]  exp;
        int n, k;
        tx = {(we ? 8'h02 : 8'h03), addr, wd};
        n = we ? 32 : 40;
        chk({tag, " idle cs"}, 32'(cs), 32'd1);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            k = (i - 1) / 2;
            // SRAM model: real data in the DATA phase, filler during the dummy/other phases
            if (!we && k >= 16) sio_in = rd[7 - 2 * (k - 16) -: 2];
            else                sio_in = 2'b01;
            // {cs, sck, oe, out, a_ack, b_ack}
            if (k < 12 || (we && k < 16))
                exp = {1'b0, 1'(i - 1), 2'b11, tx[31 - 2 * k -: 2], 2'b00};
            else
                exp = {1'b0, 1'(i - 1), 4'b0000, 2'b00};
            chk($sformatf("%s i%0d", tag, i), 32'({cs, sck, sio_oe, sio_out, a_ack, b_ack}), 32'(exp));
        end
        @(negedge clk);
        sio_in = 2'b00;
        chk({tag, " ack"}, 32'({cs, sck, sio_oe, sio_out, a_ack, b_ack}),
            32'({1'b1, 5'b00000, !is_b, is_b}));
        if (!we) chk({tag, " rdata"}, 32'(is_b ? b_rdata : a_rdata), 32'(rd));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset vals", 32'({cs, sck, sio_oe, sio_out, ready, a_ack, b_ack, a_rdata, b_rdata}),
            32'({1'b1, 24'd0}));
        @(posedge clk);
        #1 reset = 1'b0;

        // init, with an A write request raised at cycle 5 (before ready)
        check_init(1'b1);
        check_frame("a_wr", 1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00);   // ack at cycle 62
        a_req = 1'b0;
        @(negedge clk);
        chk("gap1", 32'({cs, a_ack, b_ack}), 32'b100);
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'hBEEF;
        @(negedge clk);
        check_frame("b_rd", 1'b1, 1'b0, 16'hBEEF, 8'h00, 8'h5C);
        b_req = 1'b0;
        @(negedge clk);
        chk("b_rdata hold", 32'({b_rdata, b_ack, cs}), 32'({8'h5C, 1'b0, 1'b1}));

        // both ports requesting continuously: A (last was B), B, A, B
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0010; a_wdata = 8'h3C;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0020;
        @(negedge clk);
        check_frame("arb0 A", 1'b0, 1'b1, 16'h0010, 8'h3C, 8'h00);
        @(negedge clk);
        chk("arb gap0", 32'({cs, a_ack, b_ack}), 32'b100);
        @(negedge clk);
        check_frame("arb1 B", 1'b1, 1'b0, 16'h0020, 8'h00, 8'hC3);
        @(negedge clk);
        chk("arb gap1", 32'({cs, a_ack, b_ack}), 32'b100);
        @(negedge clk);
        check_frame("arb2 A", 1'b0, 1'b1, 16'h0010, 8'h3C, 8'h00);
        @(negedge clk);
        chk("arb gap2", 32'({cs, a_ack, b_ack}), 32'b100);
        @(negedge clk);
        check_frame("arb3 B", 1'b1, 1'b0, 16'h0020, 8'h00, 8'h96);
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        chk("arb gap3", 32'({cs, a_ack, b_ack, b_rdata}), 32'({3'b100, 8'h96}));

        // B read aborted by reset during ADDR
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0F0F;
        @(negedge clk);                // grant cycle T
        repeat (12) @(negedge clk);    // T+12, inside ADDR
        chk("mid cs low", 32'({cs, sio_oe}), 32'({1'b0, 2'b11}));
        reset = 1'b1;
        b_req = 1'b0;
        @(negedge clk);
        chk("mid reset", 32'({cs, sck, sio_oe, sio_out, ready, a_ack, b_ack, b_rdata}),
            32'({1'b1, 8'd0, 8'h00}));
        @(posedge clk);
        #1 reset = 1'b0;
        check_init(1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("post idle %0d", c), 32'({cs, ready, a_ack, b_ack}), 32'b1100);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
